// File: rtl/fp_add_pkg.sv
// rtl/fp_add_pkg.sv - shared state encoding, operator codes and binary16 field widths
package fp_add_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_HAVE_OPS = 4'd1,
        ST_SETTLE   = 4'd2,
        ST_DONE     = 4'd3
    } state_t;

    localparam logic [1:0] OP_PLUS  = 2'b01;
    localparam logic [1:0] OP_MINUS = 2'b10;

    localparam int FP_SIGN_W   = 1;
    localparam int FP_EXP_W    = 5;
    localparam int FP_MAN_W    = 10;
    localparam int FP_W        = FP_SIGN_W + FP_EXP_W + FP_MAN_W;
    localparam int FP_SIGN_BIT = FP_W - 1;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer, saturating debouncer and rising-edge press pulse
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          prev;
    logic [2:0]    fill;
    logic [CW-1:0] cnt;
    logic          armed;
    logic          accept;

    // fill marks when the synchronizer holds real samples rather than reset values
    assign accept = fill[2] && (sync2 == prev) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            fill  <= 3'b000;
            cnt   <= '0;
            level <= 1'b0;
            armed <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            prev  <= sync2;
            fill  <= {fill[1:0], 1'b1};
            if (!fill[2] || (sync2 != prev)) begin
                cnt <= '0;
            end else if (cnt != CNT_LAST) begin
                cnt <= cnt + 1'b1;
            end
            if (accept) begin
                level <= sync2;
            end
            // a button held through reset must be seen released before it may press
            if (accept && !sync2) begin
                armed <= 1'b1;
            end
            press <= accept && sync2 && !level && armed;
        end
    end

endmodule

// File: rtl/fp_add_sequencer.sv
// rtl/fp_add_sequencer.sv - button-driven operand/operator sequencer around a binary16 adder
module fp_add_sequencer
    import fp_add_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SETTLE_CYCLES   = 4
) (
    input  logic            clk,
    input  logic            lcd_reset,
    input  logic            load_a_btn,
    input  logic            load_b_btn,
    input  logic            exec_btn,
    input  logic            sub_sel,
    input  logic [FP_W-1:0] key_value,
    input  logic [FP_W-1:0] dp_result,
    output logic [FP_W-1:0] a_reg,
    output logic [FP_W-1:0] b_reg,
    output logic [FP_W-1:0] c_reg,
    output logic [1:0]      op_code,
    output logic            busy,
    output logic            done,
    output logic [7:0]      status_led
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    logic [3:0]      raw_btn;
    logic [3:0]      btn_level;
    logic [3:0]      btn_press;
    logic            press_a;
    logic            press_b;
    logic            press_exec;
    logic            sub_level;
    logic            unused_btn;

    state_t          state;
    state_t          state_n;
    logic [FP_W-1:0] a_n;
    logic [FP_W-1:0] b_n;
    logic [FP_W-1:0] c_n;
    logic [1:0]      op_n;
    logic            a_valid;
    logic            a_valid_n;
    logic            b_valid;
    logic            b_valid_n;
    logic            err;
    logic            err_n;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;

    assign raw_btn = {sub_sel, exec_btn, load_b_btn, load_a_btn};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk   (clk),
            .rst_n (lcd_reset),
            .raw   (raw_btn[i]),
            .level (btn_level[i]),
            .press (btn_press[i])
        );
    end

    // buttons act on edges, the operator switch on its settled level
    assign press_a    = btn_press[0];
    assign press_b    = btn_press[1];
    assign press_exec = btn_press[2];
    assign sub_level  = btn_level[3];
    assign unused_btn = ^{btn_level[2:0], btn_press[3]};

    assign busy       = (state == ST_SETTLE);
    assign status_led = {a_valid, b_valid, busy, err, state};

    always_ff @(posedge clk or negedge lcd_reset) begin
        if (!lcd_reset) begin
            state   <= ST_IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            c_reg   <= '0;
            op_code <= OP_PLUS;
            a_valid <= 1'b0;
            b_valid <= 1'b0;
            err     <= 1'b0;
            cnt     <= '0;
        end else begin
            state   <= state_n;
            a_reg   <= a_n;
            b_reg   <= b_n;
            c_reg   <= c_n;
            op_code <= op_n;
            a_valid <= a_valid_n;
            b_valid <= b_valid_n;
            err     <= err_n;
            cnt     <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        a_n       = a_reg;
        b_n       = b_reg;
        c_n       = c_reg;
        op_n      = op_code;
        a_valid_n = a_valid;
        b_valid_n = b_valid;
        err_n     = err;
        cnt_n     = cnt;
        done      = 1'b0;
        if (state == ST_SETTLE) begin
            // every press is dropped while the datapath settles
            if (cnt == '0) begin
                c_n     = dp_result;
                done    = 1'b1;
                state_n = ST_DONE;
            end else begin
                cnt_n = cnt - 1'b1;
            end
        end else begin
            if (press_a) begin
                a_n       = key_value;
                a_valid_n = 1'b1;
                err_n     = 1'b0;
            end else if (press_b) begin
                b_n       = key_value;
                b_valid_n = 1'b1;
                err_n     = 1'b0;
            end else if (press_exec) begin
                if (state == ST_IDLE) begin
                    err_n = 1'b1;
                end else begin
                    b_n[FP_SIGN_BIT] = sub_level;
                    op_n             = sub_level ? OP_MINUS : OP_PLUS;
                    cnt_n            = SETTLE_LAST;
                    state_n          = ST_SETTLE;
                end
            end
            if ((state == ST_DONE) && (press_a || press_b)) begin
                state_n = ST_HAVE_OPS;
            end
            if ((state == ST_IDLE) && a_valid_n && b_valid_n) begin
                state_n = ST_HAVE_OPS;
            end
        end
    end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// tb/tb_fp_add_sequencer.sv - directed bench with a behavioural operand/result model
module tb_fp_add_sequencer;
    import fp_add_pkg::*;

    localparam int DEB  = 8;
    localparam int SET  = 4;
    localparam int HOLD = 24;

    logic        clk        = 1'b0;
    logic        lcd_reset  = 1'b0;
    logic        load_a_btn = 1'b0;
    logic        load_b_btn = 1'b0;
    logic        exec_btn   = 1'b0;
    logic        sub_sel    = 1'b0;
    logic [15:0] key_value  = 16'h0000;
    logic [15:0] dp_result  = 16'h0000;
    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic [15:0] c_reg;
    logic [1:0]  op_code;
    logic        busy;
    logic        done;
    logic [7:0]  status_led;

    fp_add_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .SETTLE_CYCLES  (SET)
    ) dut (
        .clk        (clk),
        .lcd_reset  (lcd_reset),
        .load_a_btn (load_a_btn),
        .load_b_btn (load_b_btn),
        .exec_btn   (exec_btn),
        .sub_sel    (sub_sel),
        .key_value  (key_value),
        .dp_result  (dp_result),
        .a_reg      (a_reg),
        .b_reg      (b_reg),
        .c_reg      (c_reg),
        .op_code    (op_code),
        .busy       (busy),
        .done       (done),
        .status_led (status_led)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic [15:0] m_a;
    logic [15:0] m_b;
    logic [15:0] m_c;
    logic [1:0]  m_op;
    logic        m_av;
    logic        m_bv;
    logic        m_err;
    state_t      m_state;

    logic [15:0] a_prev = 16'h0000;
    int          a_chg  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_a = 16'h0000; m_b = 16'h0000; m_c = 16'h0000; m_op = 2'b01;
        m_av = 1'b0; m_bv = 1'b0; m_err = 1'b0; m_state = ST_IDLE;
    endfunction

    function automatic void model_load(input bit is_a, input logic [15:0] key);
        if (m_state == ST_SETTLE) return;
        if (is_a) begin m_a = key; m_av = 1'b1; end
        else begin m_b = key; m_bv = 1'b1; end
        m_err = 1'b0;
        if (m_state == ST_DONE) m_state = ST_HAVE_OPS;
        else if (m_state == ST_IDLE && m_av && m_bv) m_state = ST_HAVE_OPS;
    endfunction

    function automatic void model_exec(input bit sub, input logic [15:0] dp);
        if (m_state == ST_IDLE) begin
            m_err = 1'b1;
        end else if (m_state != ST_SETTLE) begin
            m_b[15] = sub;
            m_op    = sub ? 2'b10 : 2'b01;
            m_c     = dp;
            m_state = ST_DONE;
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("a_reg", 32'(a_reg), 32'(m_a));
            check("b_reg", 32'(b_reg), 32'(m_b));
            check("c_reg", 32'(c_reg), 32'(m_c));
            check("op_code", 32'(op_code), 32'(m_op));
            check("status_led", 32'(status_led), 32'({m_av, m_bv, 1'b0, m_err, m_state}));
            check("idle_busy", 32'(busy), 32'(0));
            check("idle_done", 32'(done), 32'(0));
        end
    end

    always @(negedge clk) begin
        if (a_reg !== a_prev) a_chg <= a_chg + 1;
        a_prev <= a_reg;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input bit is_a, input logic [15:0] key);
        chk_en = 1'b0;
        key_value = key;
        if (is_a) load_a_btn = 1'b1; else load_b_btn = 1'b1;
        tick(HOLD);
        load_a_btn = 1'b0;
        load_b_btn = 1'b0;
        tick(HOLD);
        model_load(is_a, key);
        chk_en = 1'b1;
        tick(4);
    endtask

    task automatic do_exec(input bit sub, input logic [15:0] dp, input bit expect_run, input bit abort);
        int waited;
        int n_busy;
        bit seen_busy;
        bit seen_done;
        chk_en = 1'b0;
        sub_sel = sub;
        dp_result = dp;
        tick(HOLD);
        exec_btn = 1'b1;
        if (!expect_run) begin
            seen_busy = 1'b0;
            repeat (HOLD) begin
                tick(1);
                if (busy) seen_busy = 1'b1;
            end
            check("refused_exec_busy", 32'(seen_busy), 32'(0));
            exec_btn = 1'b0;
            tick(HOLD);
            model_exec(sub, dp);
            chk_en = 1'b1;
            tick(4);
            return;
        end
        waited = 0;
        while (busy !== 1'b1 && waited < 4 * HOLD) begin
            tick(1);
            waited++;
        end
        check("exec_enters_settle", 32'(busy), 32'(1));
        check("settle_b_sign", 32'(b_reg[15]), 32'(sub));
        check("settle_op_code", 32'(op_code), sub ? 32'h2 : 32'h1);
        if (abort) begin
            tick(2);
            lcd_reset = 1'b0;
            #1;
            check("abort_a_reg", 32'(a_reg), 32'(0));
            check("abort_b_reg", 32'(b_reg), 32'(0));
            check("abort_c_reg", 32'(c_reg), 32'(0));
            check("abort_op_code", 32'(op_code), 32'(1));
            check("abort_status", 32'(status_led), 32'(0));
            check("abort_busy", 32'(busy), 32'(0));
            seen_done = done;
            repeat (8) begin
                tick(1);
                if (done) seen_done = 1'b1;
            end
            exec_btn = 1'b0;
            tick(1);
            lcd_reset = 1'b1;
            repeat (HOLD) begin
                tick(1);
                if (done) seen_done = 1'b1;
            end
            check("abort_no_done", 32'(seen_done), 32'(0));
            model_reset();
            chk_en = 1'b1;
            tick(4);
            return;
        end
        n_busy = 1;
        waited = 0;
        while (done !== 1'b1 && waited < 4 * SET) begin
            tick(1);
            waited++;
            if (busy) n_busy++;
        end
        check("done_on_last_settle_cycle", 32'(n_busy), 32'(SET));
        check("busy_during_done", 32'(busy), 32'(1));
        tick(1);
        check("done_single_cycle", 32'(done), 32'(0));
        check("c_reg_captured", 32'(c_reg), 32'(dp));
        exec_btn = 1'b0;
        tick(HOLD);
        model_exec(sub, dp);
        chk_en = 1'b1;
        tick(4);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit seen_busy;
        model_reset();
        load_a_btn = 1'b1;
        tick(3);
        check("reset_a_reg", 32'(a_reg), 32'(0));
        check("reset_b_reg", 32'(b_reg), 32'(0));
        check("reset_c_reg", 32'(c_reg), 32'(0));
        check("reset_op_code", 32'(op_code), 32'(1));
        check("reset_status", 32'(status_led), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        lcd_reset = 1'b1;
        chk_en = 1'b1;
        tick(3 * HOLD);
        check("held_button_no_press", 32'(a_reg), 32'(0));
        load_a_btn = 1'b0;
        tick(HOLD);

        do_load(1'b1, 16'h3C00);
        do_exec(1'b0, 16'h4200, 1'b0, 1'b0);
        check("err_set_literal", 32'(status_led[4]), 32'(1));
        check("err_state_idle", 32'(status_led[3:0]), 32'(ST_IDLE));
        check("err_c_unchanged", 32'(c_reg), 32'(0));

        do_load(1'b0, 16'h4000);
        check("err_cleared_literal", 32'(status_led[4]), 32'(0));
        check("have_ops_literal", 32'(status_led[3:0]), 32'(ST_HAVE_OPS));

        do_exec(1'b0, 16'h4200, 1'b1, 1'b0);
        check("add_c_literal", 32'(c_reg), 32'h4200);
        check("add_op_literal", 32'(op_code), 32'h1);
        check("add_state_done", 32'(status_led[3:0]), 32'(ST_DONE));

        do_load(1'b1, 16'h4200);
        check("done_load_to_have_ops", 32'(status_led[3:0]), 32'(ST_HAVE_OPS));
        do_load(1'b0, 16'h3C00);
        do_exec(1'b1, 16'h4000, 1'b1, 1'b0);
        check("sub_b_literal", 32'(b_reg), 32'hBC00);
        check("sub_op_literal", 32'(op_code), 32'h2);
        check("sub_c_literal", 32'(c_reg), 32'h4000);

        chk_en = 1'b0;
        base = a_chg;
        for (int i = 0; i < 10; i++) begin
            key_value = 16'h5000 + 16'(i);
            load_a_btn = ~load_a_btn;
            tick(3);
        end
        key_value = 16'h4800;
        load_a_btn = 1'b1;
        tick(HOLD);
        load_a_btn = 1'b0;
        tick(HOLD);
        check("bounce_one_update", 32'(a_chg - base), 32'(1));
        check("bounce_a_literal", 32'(a_reg), 32'h4800);
        model_load(1'b1, 16'h4800);
        chk_en = 1'b1;
        tick(4);

        chk_en = 1'b0;
        key_value = 16'h4600;
        sub_sel = 1'b0;
        load_a_btn = 1'b1;
        exec_btn = 1'b1;
        seen_busy = 1'b0;
        repeat (HOLD) begin
            tick(1);
            if (busy) seen_busy = 1'b1;
        end
        load_a_btn = 1'b0;
        exec_btn = 1'b0;
        tick(HOLD);
        check("same_cycle_exec_dropped", 32'(seen_busy), 32'(0));
        check("same_cycle_a_literal", 32'(a_reg), 32'h4600);
        model_load(1'b1, 16'h4600);
        chk_en = 1'b1;
        tick(4);

        do_exec(1'b0, 16'h1234, 1'b1, 1'b1);
        check("after_abort_c_literal", 32'(c_reg), 32'(0));

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
